instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter ICACHE_IDX_W, default 8, meaning log2 of direct-mapped icache entries (one 32-bit word per entry), index pc[ICACHE_IDX_W+1:2].
REQ-002 Parameter BHT_IDX_W, default 8, meaning log2 of 2-bit branch history table entries, index pc[BHT_IDX_W+1:2].
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 rdy  in  1  global enable; low holds all state and registered outputs.
REQ-006 rollback  in  1  mispredict flush from ROB.
REQ-007 rollback_pc  in  32  redirect target.
REQ-008 rs_full, lsb_full, rob_full  in  1 each  downstream back-pressure.
REQ-009 inst_done  out  1  registered pulse, instruction valid to decoder.
REQ-010 inst  out  32  instruction word.
REQ-011 inst_pc  out  32  address of inst.
REQ-012 inst_pre_j  out  1  predicted taken.
REQ-013 mc_en  out  1  registered memory-controller fetch request.
REQ-014 mc_pc  out  32  word-aligned request address.
REQ-015 mc_done  in  1  one-cycle fill-complete strobe.
REQ-016 mc_data  in  32  fill word, valid with mc_done.
REQ-017 br_upd, br_upd_taken  in  1 each  committed conditional-branch outcome.
REQ-018 br_upd_pc  in  32  pc of committed branch.

Function
REQ-019 Internal pc register; states IDLE, WAIT_MEM; icache holds valid, tag pc[31:ICACHE_IDX_W+2], data per entry.
REQ-020 Priority per rdy-high cycle: rst > rollback > stall > fetch.
REQ-021 stall = rs_full | lsb_full | rob_full; while stalled in IDLE: inst_done<=0, pc held, no mc request.
REQ-022 IDLE, not stalled, hit (valid and tag match at pc): next cycle inst_done=1, inst=cached word, inst_pc=pc; sustained throughput one instruction per cycle.
REQ-023 Next pc on hit: opcode JAL -> pc+J-imm, pre_j=1; opcode BRANCH with bht[idx][1]=1 -> pc+B-imm, pre_j=1; all others incl. JALR -> pc+4, pre_j=0; immediates sign-extended, 32-bit wrap-around add.
REQ-024 IDLE, not stalled, miss: inst_done<=0, mc_en<=1, mc_pc<=pc, state<=WAIT_MEM.
REQ-025 WAIT_MEM: mc_en and mc_pc held until mc_done; on mc_done write entry at mc_pc (valid=1, tag, mc_data), mc_en<=0, state<=IDLE; refetch hits next cycle, so miss-to-issue = fill latency + 2 cycles.
REQ-026 inst_done=0 in every cycle not covered by REQ-022.
REQ-027 rollback: pc<=rollback_pc, inst_done<=0, mc_en<=0, state<=IDLE; a coincident mc_done still writes the cache at mc_pc but issues nothing.
REQ-028 BHT update on br_upd: counter at br_upd_pc index incremented if taken else decremented, saturating at 0 and 3; same-cycle lookup on same index uses pre-update value.
REQ-029 rdy low: no state, cache, BHT or output change, including ignoring mc_done and br_upd (memory controller holds mc_done while rdy low).

Reset
REQ-030 On rst: pc=0, state=IDLE, all icache valid=0, all BHT counters=2'b01, inst_done=0, inst=0, inst_pc=0, inst_pre_j=0, mc_en=0, mc_pc=0.
REQ-031 rst mid-fill abandons the request; subsequent mc_done for it is not written.

Verification
REQ-032 Reset, memory word at 0x0 = 0x00100093 (addi), fill latency 3 -> mc_en=1 mc_pc=0x0, inst_done with inst=0x00100093 inst_pc=0x0 five cycles after fill request start; next request mc_pc=0x4.
REQ-033 Cached loop of 4 instructions at 0x100 ending in JAL -0xC -> inst_done every cycle, inst_pc sequence 0x100,0x104,0x108,0x10C,0x100, pre_j=1 on 0x10C.
REQ-034 BEQ at 0x200 offset +0x20, two br_upd taken -> counter 01->10->11; next fetch inst_pre_j=1, following inst_pc=0x220; four not-taken updates saturate at 0.
REQ-035 rob_full high 3 cycles during hit stream -> inst_done=0 those cycles, pc unchanged, resumes with same inst_pc.
REQ-036 rollback with rollback_pc=0x400 during WAIT_MEM -> mc_en=0 next cycle, state IDLE, next request mc_pc=0x400; mc_done coincident with rollback yields no inst_done.

Source files
------------

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: direct-mapped icache, 2-bit BHT branch prediction,
// single outstanding memory-controller fill, rollback redirect and back-pressure stall.
module instruction_fetch #(
   parameter int ICACHE_IDX_W = 8,
   parameter int BHT_IDX_W    = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic        rollback,
   input  logic [31:0] rollback_pc,
   input  logic        rs_full,
   input  logic        lsb_full,
   input  logic        rob_full,
   output logic        inst_done,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   output logic        inst_pre_j,
   output logic        mc_en,
   output logic [31:0] mc_pc,
   input  logic        mc_done,
   input  logic [31:0] mc_data,
   input  logic        br_upd,
   input  logic        br_upd_taken,
   input  logic [31:0] br_upd_pc
);

   localparam int IC_N  = 1 << ICACHE_IDX_W;
   localparam int BHT_N = 1 << BHT_IDX_W;
   localparam int TAG_W = 30 - ICACHE_IDX_W;

   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   typedef enum logic {IDLE, WAIT_MEM} state_t;

   state_t      state;
   logic [31:0] pc;

   logic [IC_N-1:0]  ic_valid;
   logic [TAG_W-1:0] ic_tag  [IC_N];
   logic [31:0]      ic_data [IC_N];
   logic [1:0]       bht     [BHT_N];

   logic [ICACHE_IDX_W-1:0] pc_idx, fill_idx;
   logic [BHT_IDX_W-1:0]    bht_rd_idx, bht_upd_idx;
   logic                    ic_hit, stall, fill_we;
   logic [31:0]             hit_word, j_imm, b_imm, next_pc;
   logic                    pred_taken;
   logic                    unused_upd_pc_bits;

   assign pc_idx      = pc[ICACHE_IDX_W+1:2];
   assign fill_idx    = mc_pc[ICACHE_IDX_W+1:2];
   assign bht_rd_idx  = pc[BHT_IDX_W+1:2];
   assign bht_upd_idx = br_upd_pc[BHT_IDX_W+1:2];
   assign unused_upd_pc_bits = ^{br_upd_pc[31:BHT_IDX_W+2], br_upd_pc[1:0]};

   assign ic_hit   = ic_valid[pc_idx] && (ic_tag[pc_idx] == pc[31:ICACHE_IDX_W+2]);
   assign hit_word = ic_data[pc_idx];
   assign stall    = rs_full | lsb_full | rob_full;
   // A coincident rollback does not cancel the fill write; reset does.
   assign fill_we  = rdy && !rst && (state == WAIT_MEM) && mc_done;

   assign j_imm = {{12{hit_word[31]}}, hit_word[19:12], hit_word[20], hit_word[30:21], 1'b0};
   assign b_imm = {{20{hit_word[31]}}, hit_word[7], hit_word[30:25], hit_word[11:8], 1'b0};

   // NOTE: every variable assigned in always_comb gets a default first, so no path infers a latch.
   always_comb begin
      next_pc    = pc + 32'd4;
      pred_taken = 1'b0;
      if (hit_word[6:0] == OP_JAL) begin
         next_pc    = pc + j_imm;
         pred_taken = 1'b1;
      end else if ((hit_word[6:0] == OP_BRANCH) && bht[bht_rd_idx][1]) begin
         next_pc    = pc + b_imm;
         pred_taken = 1'b1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rdy) begin
         if (rst) begin
            ic_valid <= '0;
         end else if (fill_we) begin
            ic_valid[fill_idx] <= 1'b1;
         end
      end
   end

   // NOTE: tag and data arrays are deliberately not reset; the valid bits alone guard them.
   always_ff @(posedge clk) begin
      if (fill_we) begin
         ic_tag[fill_idx]  <= mc_pc[31:ICACHE_IDX_W+2];
         ic_data[fill_idx] <= mc_data;
      end
   end

   // Lookup reads the pre-edge counter, so a same-cycle update is not yet visible.
   always_ff @(posedge clk) begin
      if (rdy) begin
         if (rst) begin
            for (int i = 0; i < BHT_N; i++) bht[i] <= 2'b01;
         end else if (br_upd) begin
            if (br_upd_taken && (bht[bht_upd_idx] != 2'b11))
               bht[bht_upd_idx] <= bht[bht_upd_idx] + 2'd1;
            else if (!br_upd_taken && (bht[bht_upd_idx] != 2'b00))
               bht[bht_upd_idx] <= bht[bht_upd_idx] - 2'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rdy) begin
         if (rst) begin
            state      <= IDLE;
            pc         <= 32'd0;
            inst_done  <= 1'b0;
            inst       <= 32'd0;
            inst_pc    <= 32'd0;
            inst_pre_j <= 1'b0;
            mc_en      <= 1'b0;
            mc_pc      <= 32'd0;
         end else if (rollback) begin
            state     <= IDLE;
            pc        <= rollback_pc;
            inst_done <= 1'b0;
            mc_en     <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (stall) begin
                     inst_done <= 1'b0;
                  end else if (ic_hit) begin
                     inst_done  <= 1'b1;
                     inst       <= hit_word;
                     inst_pc    <= pc;
                     inst_pre_j <= pred_taken;
                     pc         <= next_pc;
                  end else begin
                     inst_done <= 1'b0;
                     mc_en     <= 1'b1;
                     mc_pc     <= {pc[31:2], 2'b00};
                     state     <= WAIT_MEM;
                  end
               end
               WAIT_MEM: begin
                  inst_done <= 1'b0;
                  if (mc_done) begin
                     mc_en <= 1'b0;
                     state <= IDLE;
                  end
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: reset/fill vector table, directed loop, BHT, stall and
// rollback sequences, then random traffic against an address-level reference model.
module tb_instruction_fetch;

   logic        clk = 1'b0;
   logic        rst = 1'b0, rdy = 1'b1, rollback = 1'b0;
   logic [31:0] rollback_pc = 32'd0;
   logic        rs_full = 1'b0, lsb_full = 1'b0, rob_full = 1'b0;
   logic        inst_done, inst_pre_j, mc_en;
   logic [31:0] inst, inst_pc, mc_pc;
   logic        mc_done = 1'b0;
   logic [31:0] mc_data = 32'd0;
   logic        br_upd = 1'b0, br_upd_taken = 1'b0;
   logic [31:0] br_upd_pc = 32'd0;

   instruction_fetch dut (
      .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback), .rollback_pc(rollback_pc),
      .rs_full(rs_full), .lsb_full(lsb_full), .rob_full(rob_full),
      .inst_done(inst_done), .inst(inst), .inst_pc(inst_pc), .inst_pre_j(inst_pre_j),
      .mc_en(mc_en), .mc_pc(mc_pc), .mc_done(mc_done), .mc_data(mc_data),
      .br_upd(br_upd), .br_upd_taken(br_upd_taken), .br_upd_pc(br_upd_pc)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- program memory and instruction encoders ----------------
   logic [31:0] mem [1024];

   function automatic logic [31:0] mem_rd(input logic [31:0] addr);
      return mem[addr[11:2]];
   endfunction

   function automatic logic [31:0] enc_jal(input int off);
      logic [20:0] i;
      i = off[20:0];
      return {i[20], i[10:1], i[11], i[19:12], 5'd0, 7'h6F};
   endfunction

   function automatic logic [31:0] enc_beq(input int off);
      logic [12:0] i;
      i = off[12:0];
      return {i[12], i[10:5], 5'd0, 5'd0, 3'b000, i[4:1], i[11], 7'h63};
   endfunction

   function automatic int j_off(input logic [31:0] w);
      return (w[31] ? -(1 << 20) : 0) + int'(w[19:12]) * 4096 + int'(w[20]) * 2048
             + int'(w[30:21]) * 2;
   endfunction

   function automatic int b_off(input logic [31:0] w);
      return (w[31] ? -4096 : 0) + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
   endfunction

   // ---------------- reference model: cache of whole line addresses ----------------
   logic [31:0] m_pc = 0, m_inst = 0, m_inst_pc = 0, m_mc_pc = 0;
   logic        m_done = 0, m_pre = 0, m_mc_en = 0;
   bit          m_wait = 0;
   bit          m_valid [256];
   logic [31:0] m_line_addr [256];
   logic [31:0] m_line_data [256];
   int          m_bht [256];

   task automatic model_step();
      int ci, bi;
      logic [31:0] w;
      if (!rdy) return;
      if (rst) begin
         m_pc = 0; m_wait = 0; m_done = 0; m_inst = 0; m_inst_pc = 0; m_pre = 0;
         m_mc_en = 0; m_mc_pc = 0;
         for (int k = 0; k < 256; k++) begin
            m_valid[k] = 0;
            m_bht[k] = 1;
         end
         return;
      end
      if (m_wait && mc_done) begin
         ci = int'((m_mc_pc / 4) % 256);
         m_valid[ci] = 1;
         m_line_addr[ci] = m_mc_pc;
         m_line_data[ci] = mc_data;
      end
      ci = int'((m_pc / 4) % 256);
      if (rollback) begin
         m_pc = rollback_pc; m_done = 0; m_mc_en = 0; m_wait = 0;
      end else if (m_wait) begin
         m_done = 0;
         if (mc_done) begin
            m_mc_en = 0; m_wait = 0;
         end
      end else if (rs_full || lsb_full || rob_full) begin
         m_done = 0;
      end else if (m_valid[ci] && m_line_addr[ci] == m_pc) begin
         w = m_line_data[ci];
         m_done = 1; m_inst = w; m_inst_pc = m_pc;
         bi = int'((m_pc / 4) % 256);
         if (w[6:0] == 7'h6F) begin
            m_pre = 1; m_pc = m_pc + 32'(j_off(w));
         end else if (w[6:0] == 7'h63 && m_bht[bi] >= 2) begin
            m_pre = 1; m_pc = m_pc + 32'(b_off(w));
         end else begin
            m_pre = 0; m_pc = m_pc + 4;
         end
      end else begin
         m_done = 0; m_mc_en = 1; m_mc_pc = m_pc & ~32'd3; m_wait = 1;
      end
      if (br_upd) begin
         bi = int'((br_upd_pc / 4) % 256);
         m_bht[bi] = br_upd_taken ? ((m_bht[bi] < 3) ? m_bht[bi] + 1 : 3)
                                  : ((m_bht[bi] > 0) ? m_bht[bi] - 1 : 0);
      end
   endtask

   // Memory controller answers the model's request after mem_lat cycles of mc_en.
   bit auto_mem = 1;
   int mem_cnt = 0, mem_lat = 0, fixed_lat = 3;

   task automatic tick();
      if (auto_mem) begin
         mc_done = m_mc_en && (mem_cnt == mem_lat);
         mc_data = mem_rd(m_mc_pc);
      end
      model_step();
      @(posedge clk);
      #1;
      check("inst_done", 32'(inst_done), 32'(m_done));
      if (m_done) begin
         check("inst", inst, m_inst);
         check("inst_pc", inst_pc, m_inst_pc);
         check("inst_pre_j", 32'(inst_pre_j), 32'(m_pre));
      end
      check("mc_en", 32'(mc_en), 32'(m_mc_en));
      if (m_mc_en) check("mc_pc", mc_pc, m_mc_pc);
      if (rdy) begin
         if (m_mc_en) begin
            if (mem_cnt == 0) mem_lat = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 4));
            mem_cnt++;
         end else begin
            mem_cnt = 0;
         end
      end
   endtask

   task automatic wait_pc(input logic [31:0] want, input int budget, input string name);
      bit found;
      found = 0;
      for (int i = 0; i < budget && !found; i++) begin
         tick();
         if (inst_done && inst_pc == want) found = 1;
      end
      check(name, 32'(found), 32'd1);
   endtask

   task automatic wait_any(input int budget, input string name);
      bit found;
      found = 0;
      for (int i = 0; i < budget && !found; i++) begin
         tick();
         if (inst_done) found = 1;
      end
      check(name, 32'(found), 32'd1);
   endtask

   typedef struct {
      logic        rst, rdy, mc_done;
      logic [31:0] mc_data;
      logic        e_done;
      logic [31:0] e_inst, e_pc;
      logic        e_mc_en;
      logic [31:0] e_mc_pc;
      bit          chk_inst, chk_mcpc;
   } vec_t;

   vec_t vecs [8];

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int r, off;
      logic [31:0] loop_pcs [4];

      for (int a = 0; a < 1024; a++) begin
         r = int'($urandom_range(0, 99));
         off = (int'($urandom_range(0, 32)) - 16) * 4;
         if (r < 50)      mem[a] = {12'(r), 5'd0, 3'b000, 5'd1, 7'h13};
         else if (r < 65) mem[a] = enc_jal(off);
         else if (r < 85) mem[a] = enc_beq(off);
         else if (r < 95) mem[a] = 32'h00008067;
         else             mem[a] = 32'h00002083;
      end
      mem[0]            = 32'h00100093;
      mem['h100 >> 2]   = 32'h00000013;
      mem['h104 >> 2]   = 32'h00000013;
      mem['h108 >> 2]   = 32'h00000013;
      mem['h10C >> 2]   = enc_jal(-12);
      mem['h200 >> 2]   = enc_beq(32);
      mem['h204 >> 2]   = 32'h00000013;
      mem['h220 >> 2]   = 32'h00000013;
      mem['h3F0 >> 2]   = 32'h00000013;
      mem['h400 >> 2]   = enc_jal(0);

      // Reset, first miss with a 3-cycle fill (one rdy-low cycle holding mc_done), then refetch.
      //            rst  rdy  done data          e_done e_inst        e_pc   e_mc_en e_mc_pc ci cm
      vecs[0] = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        32'h0, 1'b0, 32'h0, 1, 1};
      vecs[1] = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        32'h0, 1'b1, 32'h0, 0, 1};
      vecs[2] = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        32'h0, 1'b1, 32'h0, 0, 1};
      vecs[3] = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        32'h0, 1'b1, 32'h0, 0, 1};
      vecs[4] = '{1'b0, 1'b0, 1'b1, 32'h00100093, 1'b0, 32'h0,        32'h0, 1'b1, 32'h0, 0, 1};
      vecs[5] = '{1'b0, 1'b1, 1'b1, 32'h00100093, 1'b0, 32'h0,        32'h0, 1'b0, 32'h0, 0, 0};
      vecs[6] = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'h00100093, 32'h0, 1'b0, 32'h0, 1, 0};
      vecs[7] = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        32'h0, 1'b1, 32'h4, 0, 1};

      for (int i = 0; i < 8; i++) begin
         rst = vecs[i].rst; rdy = vecs[i].rdy;
         mc_done = vecs[i].mc_done; mc_data = vecs[i].mc_data;
         @(posedge clk);
         #1;
         check($sformatf("vec%0d inst_done", i), 32'(inst_done), 32'(vecs[i].e_done));
         check($sformatf("vec%0d mc_en", i), 32'(mc_en), 32'(vecs[i].e_mc_en));
         if (vecs[i].chk_mcpc) check($sformatf("vec%0d mc_pc", i), mc_pc, vecs[i].e_mc_pc);
         if (vecs[i].chk_inst) begin
            check($sformatf("vec%0d inst", i), inst, vecs[i].e_inst);
            check($sformatf("vec%0d inst_pc", i), inst_pc, vecs[i].e_pc);
            check($sformatf("vec%0d inst_pre_j", i), 32'(inst_pre_j), 32'd0);
         end
      end
      rdy = 1; mc_done = 0;

      // Cached four-instruction loop at 0x100.
      rst = 1; tick(); rst = 0;
      rollback = 1; rollback_pc = 32'h100; tick(); rollback = 0;
      wait_pc(32'h10C, 60, "loop_warm");
      wait_pc(32'h100, 20, "loop_wrap");
      loop_pcs = '{32'h104, 32'h108, 32'h10C, 32'h100};
      for (int i = 0; i < 4; i++) begin
         tick();
         check("loop_done", 32'(inst_done), 32'd1);
         check("loop_pc", inst_pc, loop_pcs[i]);
         check("loop_pre_j", 32'(inst_pre_j), (loop_pcs[i] == 32'h10C) ? 32'd1 : 32'd0);
      end

      // Two taken updates make the BEQ at 0x200 predict taken.
      br_upd = 1; br_upd_taken = 1; br_upd_pc = 32'h200;
      tick(); tick();
      br_upd = 0;
      rollback = 1; rollback_pc = 32'h200; tick(); rollback = 0;
      wait_pc(32'h200, 30, "beq_issue");
      check("beq_pre_j_taken", 32'(inst_pre_j), 32'd1);
      wait_any(30, "beq_target_issue");
      check("beq_target_pc", inst_pc, 32'h220);
      // Four not-taken updates from 3 must saturate at 0, not wrap to 3.
      br_upd = 1; br_upd_taken = 0; br_upd_pc = 32'h200;
      for (int i = 0; i < 4; i++) tick();
      br_upd = 0;
      rollback = 1; rollback_pc = 32'h200; tick(); rollback = 0;
      wait_pc(32'h200, 10, "beq_reissue");
      check("beq_pre_j_sat0", 32'(inst_pre_j), 32'd0);
      wait_any(30, "beq_fallthru_issue");
      check("beq_fallthru_pc", inst_pc, 32'h204);

      // Back-pressure during a hit stream.
      rollback = 1; rollback_pc = 32'h100; tick(); rollback = 0;
      wait_pc(32'h104, 10, "stall_pre");
      rob_full = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("stall_no_issue", 32'(inst_done), 32'd0);
      end
      rob_full = 0;
      tick();
      check("stall_resume_done", 32'(inst_done), 32'd1);
      check("stall_resume_pc", inst_pc, 32'h108);

      // Rollback coincident with the fill strobe while waiting on 0x3F0.
      rollback = 1; rollback_pc = 32'h3F0; tick(); rollback = 0;
      tick();
      check("rb_miss_req", 32'(mc_en), 32'd1);
      check("rb_miss_pc", mc_pc, 32'h3F0);
      auto_mem = 0;
      mc_done = 1; mc_data = mem_rd(32'h3F0);
      rollback = 1; rollback_pc = 32'h400;
      tick();
      check("rb_mc_en_drop", 32'(mc_en), 32'd0);
      check("rb_no_issue", 32'(inst_done), 32'd0);
      rollback = 0; mc_done = 0; auto_mem = 1;
      tick();
      check("rb_new_req", 32'(mc_en), 32'd1);
      check("rb_new_pc", mc_pc, 32'h400);
      check("rb_new_no_issue", 32'(inst_done), 32'd0);
      for (int i = 0; i < 10; i++) tick();
      rollback = 1; rollback_pc = 32'h3F0; tick(); rollback = 0;
      tick();
      check("rb_fill_kept_done", 32'(inst_done), 32'd1);
      check("rb_fill_kept_pc", inst_pc, 32'h3F0);

      // Random traffic against the reference model.
      fixed_lat = 0;
      for (int c = 0; c < 3000; c++) begin
         rdy          = ($urandom_range(0, 9) != 0);
         rst          = ($urandom_range(0, 199) == 0);
         rollback     = ($urandom_range(0, 32) == 0);
         rollback_pc  = 32'($urandom_range(0, 1023)) << 2;
         rs_full      = ($urandom_range(0, 19) == 0);
         lsb_full     = ($urandom_range(0, 19) == 0);
         rob_full     = ($urandom_range(0, 19) == 0);
         br_upd       = ($urandom_range(0, 4) == 0);
         br_upd_taken = ($urandom_range(0, 1) == 1);
         br_upd_pc    = 32'($urandom_range(0, 511)) << 2;
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
